// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator and its helpers.
package led_pkg;

    // Runtime-selectable display modes, as driven on the mode input.
    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } led_mode_t;

    // Travel direction of the bounce dot (UP = towards bit N_LEDS-1).
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } led_dir_t;

    // Control state of the generator, kept in one struct so checkers can bind to it.
    typedef struct packed {
        led_mode_t mode;
        led_dir_t  dir;
    } led_state_t;

endpackage

// File: rtl/led_pattern_gen_step_prescaler.sv
// Step prescaler: emits a tick on every DIV-th enabled cycle.
// tick is combinational and only asserted while en is high.
module step_prescaler #(
    parameter int unsigned DIV = 3000000,
    parameter int unsigned W   = $clog2(DIV + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("step_prescaler: DIV must be at least 1");
        end
    endgenerate

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    assign tick = en && (count == LAST);

    // Count enabled cycles 0..DIV-1; a clear restarts the period from zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: static, blink, chase and bounce patterns on N_LEDS
// outputs, advanced by a shared step prescaler.
// mode_load is a single-cycle strobe; it latches mode and static_pattern,
// restarts the step period and takes priority over a coincident step.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS   = 5,
    parameter int unsigned STEP_DIV = 3000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        mode,
    input  logic              mode_load,
    input  logic [N_LEDS-1:0] static_pattern,
    input  logic              pause,
    output logic [N_LEDS-1:0] leds,
    output logic              step
);

    generate
        if (N_LEDS < 1 || N_LEDS > 32) begin : g_bad_n
            $error("led_pattern_gen: N_LEDS must be in 1..32");
        end
    endgenerate

    localparam int unsigned       PS_W    = $clog2(STEP_DIV + 1);
    localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);

    logic              tick;
    led_state_t        state_q;
    led_state_t        state_d;
    logic [N_LEDS-1:0] pat_q;
    logic [N_LEDS-1:0] pat_d;
    logic [N_LEDS-1:0] leds_d;
    logic              step_d;

    step_prescaler #(
        .DIV (STEP_DIV),
        .W   (PS_W)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .clr  (mode_load),
        .en   (!pause),
        .tick (tick)
    );

    // Register control state, latched pattern and the LED/step outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= '{mode: MODE_STATIC, dir: DIR_UP};
            pat_q   <= '0;
            leds    <= '0;
            step    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            leds    <= leds_d;
            step    <= step_d;
        end
    end

    // Next pattern: a load initialises the chosen mode, otherwise a tick advances it.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        leds_d  = leds;
        step_d  = 1'b0;
        if (mode_load) begin
            state_d.mode = led_mode_t'(mode);
            state_d.dir  = DIR_UP;
            pat_d        = static_pattern;
            case (led_mode_t'(mode))
                MODE_STATIC, MODE_BLINK: leds_d = static_pattern;
                default:                 leds_d = LED_ONE;
            endcase
        end else if (tick) begin
            step_d = 1'b1;
            case (state_q.mode)
                MODE_STATIC: leds_d = pat_q;
                // Blink phase is implied by the outputs: lit means the next step blanks.
                MODE_BLINK:  leds_d = (leds != '0) ? '0 : pat_q;
                // Rotate left; with one LED this reduces to holding bit 0.
                MODE_CHASE:  leds_d = (leds << 1) | (leds >> (N_LEDS - 1));
                MODE_BOUNCE: begin
                    if (N_LEDS == 1) begin
                        leds_d = LED_ONE;
                    end else if (state_q.dir == DIR_UP) begin
                        // At the top end, turn around and move down in the same step.
                        if (leds[N_LEDS-1]) begin
                            state_d.dir = DIR_DOWN;
                            leds_d      = leds >> 1;
                        end else begin
                            leds_d = leds << 1;
                        end
                    end else begin
                        // At the bottom end, turn around and move up in the same step.
                        if (leds[0]) begin
                            state_d.dir = DIR_UP;
                            leds_d      = leds << 1;
                        end else begin
                            leds_d = leds >> 1;
                        end
                    end
                end
                default: leds_d = leds;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (5 LEDs / 4-cycle step, 1 LED / 1-cycle step)
// checked every cycle against an index-based reference model, plus directed sequences.
module tb_led_pattern_gen;

    localparam int N0   = 5;
    localparam int DIV0 = 4;
    localparam int N1   = 1;
    localparam int DIV1 = 1;

    typedef struct packed {
        int mode;
        int pat;
        int cnt;
        int pos;
        int d;
        bit on;
        bit step;
    } model_t;

    // ---------------- clock / reset / signals ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic [1:0]    mode           = '0;
    logic          mode_load      = 1'b0;
    logic [N0-1:0] static_pattern = '0;
    logic          pause          = 1'b0;
    logic [N0-1:0] leds;
    logic          step;

    logic [1:0]    mode1           = '0;
    logic          mode_load1      = 1'b0;
    logic [N1-1:0] static_pattern1 = '0;
    logic          pause1          = 1'b0;
    logic [N1-1:0] leds1;
    logic          step1;

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LEDS(N0), .STEP_DIV(DIV0)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mode           (mode),
        .mode_load      (mode_load),
        .static_pattern (static_pattern),
        .pause          (pause),
        .leds           (leds),
        .step           (step)
    );

    led_pattern_gen #(.N_LEDS(N1), .STEP_DIV(DIV1)) dut1 (
        .clk            (clk),
        .rstn           (rstn),
        .mode           (mode1),
        .mode_load      (mode_load1),
        .static_pattern (static_pattern1),
        .pause          (pause1),
        .leds           (leds1),
        .step           (step1)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [N0-1:0] exp_q[$];
    bit            sb_on = 1'b0;
    model_t        m0;
    model_t        m1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.pat = 0; r.cnt = 0; r.pos = 0; r.d = 1; r.on = 1'b1; r.step = 1'b0;
        return r;
    endfunction

    // One clock edge: the dot position is an integer index walking 0..n-1.
    function automatic model_t model_next(model_t s, int n, int div, bit load, bit ps, int md, int pt);
        model_t r = s;
        r.step = 1'b0;
        if (load) begin
            r.mode = md; r.pat = pt; r.cnt = 0; r.pos = 0; r.d = 1; r.on = 1'b1;
        end else if (!ps) begin
            if (r.cnt == div - 1) begin
                r.cnt  = 0;
                r.step = 1'b1;
                case (r.mode)
                    1: r.on = !r.on;
                    2: r.pos = (r.pos + 1) % n;
                    3: if (n > 1) begin
                        r.pos = r.pos + r.d;
                        if (r.pos == n - 1) r.d = -1;
                        else if (r.pos == 0) r.d = 1;
                    end
                    default: ;
                endcase
            end else begin
                r.cnt = r.cnt + 1;
            end
        end
        return r;
    endfunction

    function automatic int model_leds(model_t s);
        case (s.mode)
            0:       return s.pat;
            1:       return s.on ? s.pat : 0;
            default: return 1 << s.pos;
        endcase
    endfunction

    // ---------------- driver: one clock with per-cycle checks ----------------
    task automatic cycle();
        @(posedge clk);
        if (!rstn) begin
            m0 = model_reset();
            m1 = model_reset();
        end else begin
            m0 = model_next(m0, N0, DIV0, mode_load, pause, int'(mode), int'(static_pattern));
            m1 = model_next(m1, N1, DIV1, mode_load1, pause1, int'(mode1), int'(static_pattern1));
        end
        #1;
        check("leds", leds, model_leds(m0));
        check("step", step, m0.step);
        check("leds1", leds1, model_leds(m1));
        check("step1", step1, m1.step);
        if (sb_on && step === 1'b1) begin
            if (exp_q.size() != 0) check("sb_seq", leds, exp_q.pop_front());
            else check("sb_extra_step", step, 1'b0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load0(input logic [1:0] md, input logic [N0-1:0] pt);
        mode = md; static_pattern = pt; mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N0-1:0] hold;
        int            guard;

        m0 = model_reset();
        m1 = model_reset();

        // Reset state
        run(3);
        check("reset_leds", leds, 0);
        check("reset_step", step, 0);
        rstn = 1'b1;
        run(5);

        // STATIC 10101: steady over 40 cycles
        load0(2'd0, 5'b10101);
        check("static_load", leds, 5'b10101);
        run(40);
        check("static_hold", leds, 5'b10101);

        // CHASE sequence
        load0(2'd2, 5'b00000);
        check("chase_init", leds, 5'b00001);
        exp_q = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
        sb_on = 1'b1;
        run(6 * DIV0);
        sb_on = 1'b0;
        check("chase_drain", exp_q.size(), 0);

        // BOUNCE sequence 1,2,3,4,3,2,1,0,1 after the initial 0
        load0(2'd3, 5'b00000);
        check("bounce_init", leds, 5'b00001);
        exp_q = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                  5'b00100, 5'b00010, 5'b00001, 5'b00010};
        sb_on = 1'b1;
        run(9 * DIV0);
        sb_on = 1'b0;
        check("bounce_drain", exp_q.size(), 0);

        // BLINK with a pause mid-period
        load0(2'd1, 5'b00110);
        check("blink_on", leds, 5'b00110);
        run(6);
        hold  = leds;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("pause_hold", leds, hold);
            check("pause_step", step, 0);
        end
        pause = 1'b0;
        run(2);
        check("resume_step", step, 1);
        check("resume_leds", leds, 5'b00110);
        run(6);

        // mode_load coinciding with a tick in CHASE at 00100
        load0(2'd2, 5'b00000);
        guard = 0;
        while (!(model_leds(m0) == 4 && m0.cnt == DIV0 - 1) && guard < 40) begin
            cycle();
            guard++;
        end
        check("collide_pre", leds, 5'b00100);
        load0(2'd2, 5'b00000);
        check("collide_step", step, 0);
        check("collide_leds", leds, 5'b00001);
        run(DIV0);
        check("collide_next_step", step, 1);
        check("collide_next_leds", leds, 5'b00010);

        // Randomised loads, patterns and pause on both instances
        for (int i = 0; i < 800; i++) begin
            mode_load       = ($urandom_range(0, 19) == 0);
            mode            = 2'($urandom_range(0, 3));
            static_pattern  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) pause = !pause;
            mode_load1      = ($urandom_range(0, 9) == 0);
            mode1           = 2'($urandom_range(0, 3));
            static_pattern1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) pause1 = !pause1;
            cycle();
        end
        mode_load = 1'b0; mode_load1 = 1'b0; pause = 1'b0; pause1 = 1'b0;

        // Asynchronous reset mid-BOUNCE on both instances
        mode1 = 2'd3; mode_load1 = 1'b1;
        load0(2'd3, 5'b00000);
        mode_load1 = 1'b0;
        run(10);
        check("pre_rst_leds1", leds1, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_leds", leds, 0);
        check("async_rst_step", step, 0);
        check("async_rst_leds1", leds1, 0);
        check("async_rst_step1", step1, 0);
        run(3);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("post_rst_leds", leds, 0);
            check("post_rst_leds1", leds1, 0);
        end

        // Single-LED BOUNCE holds bit 0
        mode1 = 2'd3; mode_load1 = 1'b1;
        cycle();
        mode_load1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("n1_bounce", leds1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
